// File: rtl/gat_stage_scheduler.sv
// rtl/gat_stage_scheduler.sv - GAT layer stage sequencer with per-stage watchdog
//
// Runs SPMM once, then DMVM -> SM -> AGGR for each subgraph, handshaking each
// engine with one-cycle start pulses and done pulses.
//
// Optional feature macro: GAT_SCHED_PERF_EN (per-stage cycle counters).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_i, num_subgraph_i  layer start (IDLE only) and subgraph count
//   *_start_o                one-cycle stage start pulses (spmm, dmvm, sm, aggr)
//   *_done_i                 stage completion pulses
//   subgraph_idx_o           current subgraph index
//   busy_o, done_o           layer running / one-cycle layer complete
//   err_o, err_stage_o       sticky watchdog error and offending stage
//   *_cyc_o                  per-stage cycle counters (zero without the macro)
module gat_stage_scheduler #(
    parameter int SG_W    = 16,
    parameter int TIMEOUT = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [SG_W-1:0] num_subgraph_i,
    output logic            spmm_start_o,
    output logic            dmvm_start_o,
    output logic            sm_start_o,
    output logic            aggr_start_o,
    input  logic            spmm_done_i,
    input  logic            dmvm_done_i,
    input  logic            sm_done_i,
    input  logic            aggr_done_i,
    output logic [SG_W-1:0] subgraph_idx_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [1:0]      err_stage_o,
    output logic [31:0]     spmm_cyc_o,
    output logic [31:0]     dmvm_cyc_o,
    output logic [31:0]     sm_cyc_o,
    output logic [31:0]     aggr_cyc_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPMM,
        S_DMVM,
        S_SM,
        S_AGGR,
        S_DONE
    } state_t;

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t          state_q, state_d;
    logic            entry_q, entry_d;
    logic [WD_W-1:0] wd_q;
    logic [SG_W-1:0] cnt_q, cnt_d;
    logic [SG_W-1:0] idx_q, idx_d;
    logic            err_q, err_d;
    logic [1:0]      err_stage_q, err_stage_d;

    logic            in_stage;
    logic            stage_done;
    logic [1:0]      stage_code;
    logic            done_acc;
    logic            wd_hit;
    logic            start_acc;

    always_comb begin
        in_stage   = 1'b0;
        stage_done = 1'b0;
        stage_code = 2'd0;
        case (state_q)
            S_SPMM: begin in_stage = 1'b1; stage_done = spmm_done_i; stage_code = 2'd0; end
            S_DMVM: begin in_stage = 1'b1; stage_done = dmvm_done_i; stage_code = 2'd1; end
            S_SM:   begin in_stage = 1'b1; stage_done = sm_done_i;   stage_code = 2'd2; end
            S_AGGR: begin in_stage = 1'b1; stage_done = aggr_done_i; stage_code = 2'd3; end
            default: ;
        endcase
    end

    // The done pulse is ignored in the start-pulse cycle so an engine that
    // still holds done from a previous run cannot retire the new run.
    assign done_acc  = in_stage && !entry_q && stage_done;
    // Fires in the stage's TIMEOUT-th cycle; the error is visible one cycle
    // later, i.e. exactly TIMEOUT cycles after the start pulse.
    assign wd_hit    = (TIMEOUT != 0) && in_stage && (wd_q == WD_W'(TIMEOUT - 1));
    assign start_acc = (state_q == S_IDLE) && start_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        err_d       = err_q;
        err_stage_d = err_stage_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_SPMM;
                    cnt_d       = num_subgraph_i;
                    idx_d       = '0;
                    err_d       = 1'b0;
                    err_stage_d = 2'd0;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (done_acc) begin
                    case (state_q)
                        S_SPMM:  state_d = (cnt_q != '0) ? S_DMVM : S_DONE;
                        S_DMVM:  state_d = S_SM;
                        S_SM:    state_d = S_AGGR;
                        default: begin
                            if (idx_q == cnt_q - SG_W'(1)) begin
                                state_d = S_DONE;
                            end else begin
                                idx_d   = idx_q + SG_W'(1);
                                state_d = S_DMVM;
                            end
                        end
                    endcase
                end else if (wd_hit) begin
                    err_d       = 1'b1;
                    err_stage_d = stage_code;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    // Every entry into a stage is a state change (AGGR->DMVM included), so
    // a change of state into a stage marks the start-pulse cycle.
    assign entry_d = (state_d != state_q) &&
                     (state_d == S_SPMM || state_d == S_DMVM ||
                      state_d == S_SM   || state_d == S_AGGR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            entry_q     <= 1'b0;
            wd_q        <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            err_stage_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            err_stage_q <= err_stage_d;
            if (entry_d) begin
                wd_q <= '0;
            end else if (in_stage && TIMEOUT != 0) begin
                wd_q <= wd_q + WD_W'(1);
            end
        end
    end

    assign spmm_start_o   = entry_q && (state_q == S_SPMM);
    assign dmvm_start_o   = entry_q && (state_q == S_DMVM);
    assign sm_start_o     = entry_q && (state_q == S_SM);
    assign aggr_start_o   = entry_q && (state_q == S_AGGR);
    assign busy_o         = in_stage;
    assign done_o         = (state_q == S_DONE);
    assign subgraph_idx_o = idx_q;
    assign err_o          = err_q;
    assign err_stage_o    = err_stage_q;

`ifdef GAT_SCHED_PERF_EN
    logic [3:0][31:0] cyc_q;

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            cyc_q <= '0;
        end else if (in_stage && cyc_q[stage_code] != 32'hFFFF_FFFF) begin
            cyc_q[stage_code] <= cyc_q[stage_code] + 32'd1;
        end
    end

    assign spmm_cyc_o = cyc_q[0];
    assign dmvm_cyc_o = cyc_q[1];
    assign sm_cyc_o   = cyc_q[2];
    assign aggr_cyc_o = cyc_q[3];
`else
    assign spmm_cyc_o = 32'd0;
    assign dmvm_cyc_o = 32'd0;
    assign sm_cyc_o   = 32'd0;
    assign aggr_cyc_o = 32'd0;
`endif

endmodule
